ysyx_23060171_wbu: RTL and testbench
====================================

// Module: ysyx_23060171_wbu
// PURPOSE
//  Write-back unit: final pipeline stage directly upstream of the general-purpose register file.
//  Accepts one retiring instruction per handshake from EXU/LSU and holds it in a one-entry buffer.
//  Selects and formats the result, then drives the register-file write port (wen/waddr/wdata).
//  Reports commit (pc, next pc) to the IFU via a valid/ready handshake.
// PARAMETERS
//  ADDR_WIDTH  5   register index width (32 GPRs)
//  DATA_WIDTH  32  datapath / register width
// PORTS
//  clk           in   1   clock, all state updates on posedge
//  rst_n         in   1   asynchronous active-low reset
//  in_valid      in   1   upstream instruction valid
//  in_ready      out  1   WBU can accept this cycle
//  in_pc         in   32  pc of retiring instruction
//  in_dnpc       in   32  dynamic next pc
//  in_rd         in   5   destination register index
//  in_rd_wen     in   1   instruction writes rd
//  in_wb_sel     in   2   result source: ALU/MEM/PC4/CSR (wb_sel_e)
//  in_alu_res    in   32  ALU result; low 2 bits = load address offset
//  in_mem_rdata  in   32  raw aligned 32-bit load word
//  in_csr_rdata  in   32  CSR read value
//  in_ld_type    in   3   load size/sign (funct3 encoding: LB/LH/LW/LBU/LHU)
//  gpr_wen       out  1   register-file write enable
//  gpr_waddr     out  5   register-file write index
//  gpr_wdata     out  32  register-file write data
//  out_valid     out  1   commit valid to IFU
//  out_ready     in   1   IFU accepts commit
//  out_pc        out  32  committed pc
//  out_dnpc      out  32  committed next pc
// BEHAVIOUR
//  - Reset: entry_valid=0; out_valid=0, gpr_wen=0, gpr_waddr=0, gpr_wdata=0, out_pc=out_dnpc=0.
//  - in_ready = !entry_valid || (out_valid && out_ready); accept on in_valid && in_ready.
//  - Accept at edge N -> entry_valid=1 during cycle N+1 -> out_valid=1 in cycle N+1 (1-cycle latency).
//  - fire = out_valid && out_ready; gpr_wen = fire && rd_wen && (rd != 0); x0 never written.
//  - gpr_waddr/gpr_wdata are driven from the held entry whenever entry_valid, else 0.
//  - Simultaneous fire and accept: entry replaced at the same edge, no bubble (throughput 1/cycle).
//  - out_ready low: entry held stable, all outputs stable, in_ready=0, no GPR write.
//  - wdata: ALU->alu_res; PC4->pc+4 (mod 2^32, wrap 0xFFFFFFFC->0); CSR->csr_rdata; MEM->load_ext.
//  - load_ext: byte/half selected by alu_res[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthru.
//  - Misaligned half (offset 3) is not checked here; uses byte lanes [31:24] zero-padded.
//  - Illegal wb_sel/ld_type: wdata = 0, instruction still commits.
//  - Reset mid-operation: held entry discarded, no GPR write, no commit emitted.
// CONFIGURATION
//  YSYX_23060171_WBU_INSTRET_EN defined: extra port instret out 64, counts fires, reset 0,
//   increments by 1 per fire, wraps at 2^64-1 -> 0.
//  Undefined: no instret port, no counter logic; all other behaviour identical.
// STRUCTURE
//  Package ysyx_23060171_pkg: wb_sel_e (WB_ALU=0, WB_MEM=1, WB_PC4=2, WB_CSR=3), LD_* funct3
//   constants, XLEN=32.
//  Sub-module ysyx_23060171_load_ext: combinational align + sign/zero extension.
//  Top: one-entry buffer, handshake logic, result mux, optional instret counter.
// TESTING
//  - Reset asserted mid-cycle with entry held -> outputs 0 immediately, no gpr_wen after release.
//  - in_alu_res=0x1234, wb_sel=ALU, rd=5, out_ready=1 -> next cycle gpr_wen=1, waddr=5, wdata=0x1234.
//  - rd=0, rd_wen=1 -> out_valid=1 and commit fires, gpr_wen stays 0.
//  - mem_rdata=0x80FF7F01, off=1, LB -> 0x0000007F; off=2, LBU -> 0x000000FF; off=2, LH -> 0xFFFF80FF.
//  - out_ready low 3 cycles -> in_ready=0, outputs stable, exactly one write when ready rises.
//  - Back-to-back 8 instrs, out_ready=1 -> 8 writes in 8 consecutive cycles;
//    with INSTRET_EN, instret=8.

Source files
------------

// File: rtl/ysyx_23060171_wbu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060171_pkg
//   Shared definitions for the write-back unit: datapath width, the
//   write-back source select encoding and the load size/sign (funct3) codes.
//   No ports (package).
// ----------------------------------------------------------------------------
package ysyx_23060171_pkg;

    localparam int XLEN = 32;

    // Write-back result source
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_e;

    // Load type, RISC-V funct3 encoding
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

endpackage

// File: rtl/ysyx_23060171_wbu_load_ext.sv
// ----------------------------------------------------------------------------
// ysyx_23060171_load_ext
//   Combinational load formatter: picks the addressed byte/halfword out of an
//   aligned 32-bit load word and sign- or zero-extends it.
// Ports:
//   i_word    in  XLEN  raw aligned load word
//   i_offset  in  2     byte offset within the word (address[1:0])
//   i_ld_type in  3     funct3 load type (LB/LH/LW/LBU/LHU)
//   o_data    out XLEN  formatted load value (0 for unknown load types)
// ----------------------------------------------------------------------------
module ysyx_23060171_load_ext
    import ysyx_23060171_pkg::*;
(
    input  logic [XLEN-1:0] i_word,
    input  logic [1:0]      i_offset,
    input  logic [2:0]      i_ld_type,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_shifted;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    // Shifting the addressed lane down to bit 0 handles every offset in one
    // place. A halfword at offset 3 naturally picks up [31:24] with zeros
    // above it; misalignment is trapped elsewhere in the pipeline.
    assign w_shifted = i_word >> {i_offset, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_shifted[15:0];

    always_comb begin
        o_data = '0;
        case (i_ld_type)
            LD_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            LD_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
            LD_LW:   o_data = i_word;
            LD_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
            LD_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_23060171_wbu.sv
// ----------------------------------------------------------------------------
// ysyx_23060171_wbu
//   Write-back unit. Holds one retiring instruction in a single-entry buffer,
//   drives the GPR write port from it and reports the commit (pc, dnpc) to
//   the IFU.
//
//   Handshakes (both sides): a transfer happens on a rising clock edge where
//   valid && ready are both high. valid never depends on ready; in_ready
//   depends on out_ready so a commit and a new accept can share one edge.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              upstream (EXU/LSU) handshake
//   in_pc, in_dnpc                 pc and dynamic next pc of the instruction
//   in_rd, in_rd_wen               destination register and its write flag
//   in_wb_sel                      result source (wb_sel_e)
//   in_alu_res                     ALU result; [1:0] is the load offset
//   in_mem_rdata, in_csr_rdata     raw load word, CSR read value
//   in_ld_type                     funct3 load type
//   gpr_wen/gpr_waddr/gpr_wdata    register-file write port
//   out_valid/out_ready            commit handshake to IFU
//   out_pc, out_dnpc               committed pc / next pc
//   instret (optional)             64-bit retired-instruction counter
//
// Configuration macro: YSYX_23060171_WBU_INSTRET_EN adds the instret port
// and counter; without it the unit has no counter logic at all.
// ----------------------------------------------------------------------------
module ysyx_23060171_wbu
    import ysyx_23060171_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_dnpc,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic [1:0]            in_wb_sel,
    input  logic [DATA_WIDTH-1:0] in_alu_res,
    input  logic [DATA_WIDTH-1:0] in_mem_rdata,
    input  logic [DATA_WIDTH-1:0] in_csr_rdata,
    input  logic [2:0]            in_ld_type,
    output logic                  gpr_wen,
    output logic [ADDR_WIDTH-1:0] gpr_waddr,
    output logic [DATA_WIDTH-1:0] gpr_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_dnpc
`ifdef YSYX_23060171_WBU_INSTRET_EN
    ,
    output logic [63:0]           instret
`endif
);

    // Held entry. The result is formatted on the way in so only the final
    // write data is stored, not the four candidate sources.
    logic                  r_entry_valid;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_dnpc;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic                  r_rd_wen;
    logic [DATA_WIDTH-1:0] r_wdata;

    wb_sel_e               w_sel;
    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_fire;
    logic                  w_accept;

    assign w_sel    = wb_sel_e'(in_wb_sel);
    assign w_fire   = r_entry_valid && out_ready;
    assign in_ready = !r_entry_valid || w_fire;
    assign w_accept = in_valid && in_ready;

    ysyx_23060171_load_ext u_load_ext (
        .i_word    (in_mem_rdata),
        .i_offset  (in_alu_res[1:0]),
        .i_ld_type (in_ld_type),
        .o_data    (w_load)
    );

    always_comb begin
        w_wdata = '0;
        case (w_sel)
            WB_ALU:  w_wdata = in_alu_res;
            WB_MEM:  w_wdata = w_load;
            WB_PC4:  w_wdata = in_pc + DATA_WIDTH'(4);
            WB_CSR:  w_wdata = in_csr_rdata;
            default: w_wdata = '0;
        endcase
    end

    // A fire and an accept on the same edge simply overwrite the entry, so
    // the buffer sustains one instruction per cycle with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry_valid <= 1'b0;
            r_pc          <= '0;
            r_dnpc        <= '0;
            r_rd          <= '0;
            r_rd_wen      <= 1'b0;
            r_wdata       <= '0;
        end else if (w_accept) begin
            r_entry_valid <= 1'b1;
            r_pc          <= in_pc;
            r_dnpc        <= in_dnpc;
            r_rd          <= in_rd;
            r_rd_wen      <= in_rd_wen && (in_rd != '0);  // x0 is never written
            r_wdata       <= w_wdata;
        end else if (w_fire) begin
            r_entry_valid <= 1'b0;
        end
    end

    assign out_valid = r_entry_valid;
    assign gpr_wen   = w_fire && r_rd_wen;
    assign gpr_waddr = r_entry_valid ? r_rd    : '0;
    assign gpr_wdata = r_entry_valid ? r_wdata : '0;
    assign out_pc    = r_entry_valid ? r_pc    : '0;
    assign out_dnpc  = r_entry_valid ? r_dnpc  : '0;

`ifdef YSYX_23060171_WBU_INSTRET_EN
    logic [63:0] r_instret;

    // Free-running; wraps naturally from all-ones to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_fire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`endif

endmodule

// File: tb/tb_ysyx_23060171_wbu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060171_wbu
//   Self-checking bench for the write-back unit. A reference model of the
//   result formatting and of the one-entry buffer occupancy predicts every
//   output; expected commits are queued on accept and consumed on fire.
//   Define YSYX_23060171_WBU_INSTRET_EN to also exercise the instret port.
// ----------------------------------------------------------------------------
module tb_ysyx_23060171_wbu;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0, in_dnpc = '0;
    logic [4:0]  in_rd = '0;
    logic        in_rd_wen = 1'b0;
    logic [1:0]  in_wb_sel = '0;
    logic [31:0] in_alu_res = '0, in_mem_rdata = '0, in_csr_rdata = '0;
    logic [2:0]  in_ld_type = '0;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_dnpc;
`ifdef YSYX_23060171_WBU_INSTRET_EN
    logic [63:0] instret;
`endif

    ysyx_23060171_wbu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_dnpc      (in_dnpc),
        .in_rd        (in_rd),
        .in_rd_wen    (in_rd_wen),
        .in_wb_sel    (in_wb_sel),
        .in_alu_res   (in_alu_res),
        .in_mem_rdata (in_mem_rdata),
        .in_csr_rdata (in_csr_rdata),
        .in_ld_type   (in_ld_type),
        .gpr_wen      (gpr_wen),
        .gpr_waddr    (gpr_waddr),
        .gpr_wdata    (gpr_wdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_dnpc     (out_dnpc)
`ifdef YSYX_23060171_WBU_INSTRET_EN
        ,
        .instret      (instret)
`endif
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] dnpc;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    int  n_wr   = 0;
    int  n_fire = 0;
    bit  occ    = 1'b0;  // model: buffer holds an instruction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference result formatting, written lane-by-lane.
    function automatic logic [31:0] model_wdata(input logic [1:0] sel, input logic [31:0] pc,
                                                input logic [31:0] alu, input logic [31:0] mem,
                                                input logic [31:0] csr, input logic [2:0] ld);
        logic [7:0]  b;
        logic [15:0] h;
        case (alu[1:0])
            2'd0:    begin b = mem[7:0];   h = mem[15:0];           end
            2'd1:    begin b = mem[15:8];  h = mem[23:8];           end
            2'd2:    begin b = mem[23:16]; h = mem[31:16];          end
            default: begin b = mem[31:24]; h = {8'h00, mem[31:24]}; end
        endcase
        case (sel)
            2'd0: return alu;
            2'd2: return pc + 32'd4;
            2'd3: return csr;
            default: begin
                case (ld)
                    3'b000:  return {{24{b[7]}}, b};
                    3'b001:  return {{16{h[15]}}, h};
                    3'b010:  return mem;
                    3'b100:  return {24'h0, b};
                    3'b101:  return {16'h0, h};
                    default: return 32'h0;
                endcase
            end
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic rwen, input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] csr, input logic [2:0] ld);
        in_valid = v; in_pc = pc; in_dnpc = pc + 32'd4; in_rd = rd; in_rd_wen = rwen;
        in_wb_sel = sel; in_alu_res = alu; in_mem_rdata = mem; in_csr_rdata = csr;
        in_ld_type = ld;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)));
    endtask

    // One clock cycle: check all outputs against the model at the falling
    // edge, update the scoreboard, then advance past the rising edge.
    task automatic cyc();
        exp_t e;
        logic acc, fire;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(occ));
        chk("in_ready", 64'(in_ready), 64'(!occ || out_ready));
        fire = occ && out_ready;
        if (occ) begin
            e = exp_q[0];
            chk("gpr_wen", 64'(gpr_wen), 64'(out_ready && e.wen));
            chk("gpr_waddr", 64'(gpr_waddr), 64'(e.rd));
            chk("gpr_wdata", 64'(gpr_wdata), 64'(e.wdata));
            chk("out_pc", 64'(out_pc), 64'(e.pc));
            chk("out_dnpc", 64'(out_dnpc), 64'(e.dnpc));
        end else begin
            chk("idle_wen", 64'(gpr_wen), 64'd0);
            chk("idle_waddr", 64'(gpr_waddr), 64'd0);
            chk("idle_wdata", 64'(gpr_wdata), 64'd0);
        end
        if (gpr_wen) n_wr++;
        acc = in_valid && (!occ || out_ready);
        if (fire) begin
            void'(exp_q.pop_front());
            n_fire++;
        end
        if (acc) begin
            e.wen   = in_rd_wen && (in_rd != 5'd0);
            e.rd    = in_rd;
            e.wdata = model_wdata(in_wb_sel, in_pc, in_alu_res, in_mem_rdata, in_csr_rdata, in_ld_type);
            e.pc    = in_pc;
            e.dnpc  = in_dnpc;
            exp_q.push_back(e);
        end
        occ = acc ? 1'b1 : (fire ? 1'b0 : occ);
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for a single cycle, then drop in_valid.
    task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic rwen,
                         input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] csr, input logic [2:0] ld);
        drive(1'b1, pc, rd, rwen, sel, alu, mem, csr, ld);
        cyc();
        in_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int wr0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_gpr_wen", 64'(gpr_wen), 64'd0);
        chk("rst_waddr", 64'(gpr_waddr), 64'd0);
        chk("rst_wdata", 64'(gpr_wdata), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_dnpc", 64'(out_dnpc), 64'd0);
`ifdef YSYX_23060171_WBU_INSTRET_EN
        chk("rst_instret", instret, 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU result, one-cycle latency
        out_ready = 1'b1;
        issue(32'h8000_0000, 5'd5, 1'b1, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 3'b010);
        chk("alu_wen", 64'(gpr_wen), 64'd1);
        chk("alu_waddr", 64'(gpr_waddr), 64'd5);
        chk("alu_wdata", 64'(gpr_wdata), 64'h1234);
        cyc();

        // rd = x0: commits but never writes
        issue(32'h8000_0004, 5'd0, 1'b1, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 3'b010);
        chk("x0_out_valid", 64'(out_valid), 64'd1);
        chk("x0_wen", 64'(gpr_wen), 64'd0);
        cyc();

        // Load formatting
        issue(32'h8000_0008, 5'd6, 1'b1, 2'd1, 32'h0000_1001, 32'h80FF_7F01, 32'h0, 3'b000);
        chk("lb_off1", 64'(gpr_wdata), 64'h0000_007F);
        cyc();
        issue(32'h8000_000C, 5'd7, 1'b1, 2'd1, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 3'b100);
        chk("lbu_off2", 64'(gpr_wdata), 64'h0000_00FF);
        cyc();
        issue(32'h8000_0010, 5'd8, 1'b1, 2'd1, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 3'b001);
        chk("lh_off2", 64'(gpr_wdata), 64'hFFFF_80FF);
        cyc();
        issue(32'h8000_0014, 5'd9, 1'b1, 2'd1, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 3'b001);
        chk("lh_off3", 64'(gpr_wdata), 64'h0000_0080);
        cyc();
        issue(32'h8000_0018, 5'd10, 1'b1, 2'd1, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 3'b011);
        chk("ld_illegal", 64'(gpr_wdata), 64'h0);
        chk("ld_illegal_commit", 64'(out_valid), 64'd1);
        cyc();

        // PC+4 wrap and CSR source
        issue(32'hFFFF_FFFC, 5'd1, 1'b1, 2'd2, 32'h0, 32'h0, 32'h0, 3'b010);
        chk("pc4_wrap", 64'(gpr_wdata), 64'h0);
        cyc();
        issue(32'h8000_0020, 5'd2, 1'b1, 2'd3, 32'h0, 32'h0, 32'hCAFE_F00D, 3'b010);
        chk("csr_wdata", 64'(gpr_wdata), 64'hCAFE_F00D);
        cyc();

        // Back-pressure: entry held three cycles, exactly one write on release
        out_ready = 1'b0;
        issue(32'h8000_0100, 5'd11, 1'b1, 2'd0, 32'h1111_1111, 32'h0, 32'h0, 3'b010);
        drive(1'b1, 32'h8000_0104, 5'd12, 1'b1, 2'd0, 32'h2222_2222, 32'h0, 32'h0, 3'b010);
        wr0 = n_wr;
        repeat (3) cyc();
        chk("stall_no_write", 64'(n_wr - wr0), 64'd0);
        out_ready = 1'b1;
        cyc();
        chk("stall_one_write", 64'(n_wr - wr0), 64'd1);
        in_valid = 1'b0;
        cyc();

        // Random traffic with random back-pressure
        for (int i = 0; i < 40; i++) begin
            drive_rand(1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        // Reset mid-operation with an entry held
        out_ready = 1'b0;
        issue(32'h8000_0200, 5'd13, 1'b1, 2'd0, 32'h3333_3333, 32'h0, 32'h0, 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_wen", 64'(gpr_wen), 64'd0);
        chk("midrst_waddr", 64'(gpr_waddr), 64'd0);
        chk("midrst_wdata", 64'(gpr_wdata), 64'd0);
        chk("midrst_out_pc", 64'(out_pc), 64'd0);
        exp_q.delete();
        occ = 1'b0;
        n_fire = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wr0 = n_wr;
        repeat (3) cyc();
        chk("midrst_no_write", 64'(n_wr - wr0), 64'd0);

        // Back-to-back: 8 instructions, 8 writes on consecutive cycles
        wr0 = n_wr;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h8000_1000 + 32'(i * 4), 5'($urandom_range(1, 31)), 1'b1,
                  2'd0, $urandom, 32'h0, 32'h0, 3'b010);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        chk("b2b_writes", 64'(n_wr - wr0), 64'd8);
`ifdef YSYX_23060171_WBU_INSTRET_EN
        chk("instret_8", instret, 64'd8);
        chk("instret_model", instret, 64'(n_fire));
`endif

        // Drain and make sure nothing is left outstanding
        repeat (2) cyc();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
